// File: rtl/key_xor_serial.sv
// Serial AES-128/192/256 round-key XOR stage: one shared XOR, one word/cycle.
// Define KEYXOR_ZEROIZE_EN to add abort_i and zeroize the key register on exit.
module key_xor_serial #(
    parameter int WORD_W = 32,
    parameter int MAX_NK = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     start_i,
    output logic                     ready_o,
    input  logic [1:0]               mode_i,
    input  logic [WORD_W-1:0]        temp_word_i,
    input  logic [MAX_NK*WORD_W-1:0] prev_key_i,
    output logic                     sub_req_o,
    output logic [WORD_W-1:0]        sub_word_o,
    input  logic                     sub_valid_i,
    input  logic [WORD_W-1:0]        sub_word_i,
    output logic                     key_valid_o,
    input  logic                     key_ready_i,
    output logic [MAX_NK*WORD_W-1:0] key_o,
    output logic                     busy_o,
`ifdef KEYXOR_ZEROIZE_EN
    input  logic                     abort_i,
`endif
    output logic                     err_o
);

    localparam int IW = $clog2(MAX_NK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SUB_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_last;
    logic              r_nk8;
    logic              r_err;
    logic [WORD_W-1:0] r_temp;
    logic [WORD_W-1:0] r_sub;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_prev [MAX_NK];
    logic [WORD_W-1:0] r_key  [MAX_NK];

    logic              w_accept;
    logic              w_illegal;
    logic              w_abort;
    logic [WORD_W-1:0] w_seed;
    logic [WORD_W-1:0] w_acc;

    assign w_accept  = (r_state == S_IDLE) && start_i && (mode_i != 2'b11);
    assign w_illegal = (r_state == S_IDLE) && start_i && (mode_i == 2'b11);

`ifdef KEYXOR_ZEROIZE_EN
    assign w_abort = abort_i && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Word 0 is seeded by temp, word 4 of AES-256 by the S-box result.
    always_comb begin
        w_seed = r_acc;
        unique case (1'b1)
            (r_idx == '0):                 w_seed = r_temp;
            (r_nk8 && (r_idx == IW'(4))): w_seed = r_sub;
            default:                       w_seed = r_acc;
        endcase
    end

    assign w_acc = w_seed ^ r_prev[r_idx];
    assign err_o = r_err;

    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        busy_o      = 1'b1;
        sub_req_o   = 1'b0;
        sub_word_o  = '0;
        key_valid_o = 1'b0;
        key_o       = '0;
        unique case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_idx == r_last)
                    w_state_nxt = S_HOLD;
                else if (r_nk8 && (r_idx == IW'(3)))
                    w_state_nxt = S_SUB_WAIT;
            end
            S_SUB_WAIT: begin
                sub_req_o  = 1'b1;
                sub_word_o = r_key[3];
                if (sub_valid_i) w_state_nxt = S_RUN;
            end
            S_HOLD: begin
                key_valid_o = 1'b1;
                for (int j = 0; j < MAX_NK; j++)
                    key_o[(MAX_NK-j)*WORD_W-1 -: WORD_W] = r_key[j];
                if (key_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_nk8   <= 1'b0;
            r_err   <= 1'b0;
            r_temp  <= '0;
            r_sub   <= '0;
            r_acc   <= '0;
            for (int j = 0; j < MAX_NK; j++) begin
                r_prev[j] <= '0;
                r_key[j]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_illegal || w_abort;
            if (w_abort) begin
                r_temp <= '0;
                r_sub  <= '0;
                r_acc  <= '0;
                for (int j = 0; j < MAX_NK; j++) r_key[j] <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_temp <= temp_word_i;
                            r_idx  <= '0;
                            r_nk8  <= (mode_i == 2'b10);
                            unique case (mode_i)
                                2'b00:   r_last <= IW'(3);
                                2'b01:   r_last <= IW'(5);
                                default: r_last <= IW'(7);
                            endcase
                            for (int j = 0; j < MAX_NK; j++) begin
                                r_prev[j] <= prev_key_i[(MAX_NK-j)*WORD_W-1 -: WORD_W];
                                r_key[j]  <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        r_key[r_idx] <= w_acc;
                        r_acc        <= w_acc;
                        r_idx        <= r_idx + 1'b1;
                    end
                    S_SUB_WAIT: begin
                        if (sub_valid_i) begin
                            r_sub <= sub_word_i;
                            r_idx <= IW'(4);
                        end
                    end
                    S_HOLD: begin
`ifdef KEYXOR_ZEROIZE_EN
                        if (key_ready_i)
                            for (int j = 0; j < MAX_NK; j++) r_key[j] <= '0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/key_xor_serial.md
Name: key_xor_serial

Overview:
- Parametrised successor to the 4-word AES-128 key-expansion XOR stage. Computes one round key for AES-128, AES-192 or AES-256 (Nk = 4/6/8 words).
- Uses a single shared WORD_W XOR, serialised one word per cycle, with a registered output.
- For AES-256, the word-4 SubWord step goes through an external S-box handshake.
- Sits between the RotWord/SubWord/Rcon stage and the round-key store, with valid/ready handshakes on both sides.

Parameters:
- WORD_W, 32, key word width in bits.
- MAX_NK, 8, maximum words per key; buses are MAX_NK*WORD_W wide.

Ports:
- clk_i, input, 1, clock.
- rst_n, input, 1, asynchronous, active-low reset.
- start_i, input, 1, request valid.
- ready_o, output, 1, block can accept a request (IDLE only).
- mode_i, input, 2, key size: 00 = Nk 4, 01 = Nk 6, 10 = Nk 8, 11 = illegal.
- temp_word_i, input, WORD_W, transformed word (RotWord/SubWord/Rcon already applied).
- prev_key_i, input, MAX_NK*WORD_W, previous key; word j at bits [(MAX_NK-j)*WORD_W-1 -: WORD_W].
- sub_req_o, output, 1, SubWord request (AES-256 only).
- sub_word_o, output, WORD_W, word to substitute (new word 3).
- sub_valid_i, input, 1, S-box result valid.
- sub_word_i, input, WORD_W, SubWord result.
- key_valid_o, output, 1, round key valid.
- key_ready_i, input, 1, consumer accepts key.
- key_o, output, MAX_NK*WORD_W, round key, same word layout as prev_key_i.
- busy_o, output, 1, not IDLE.
- err_o, output, 1, one-cycle pulse on illegal mode (and on abort, if enabled).

Behaviour:
- Reset: state IDLE, counter and all internal registers 0. Outputs: ready_o = 1; every other output 0.
- States: IDLE, RUN, SUB_WAIT, HOLD.

IDLE:
- ready_o = 1.
- On start_i & ready_o with a legal mode: register mode, temp_word_i and prev_key_i; clear the key register; set idx = 0; go to RUN.
- On start_i with mode 11: pulse err_o for one cycle, capture nothing, stay in IDLE.

RUN:
- Each cycle: acc = seed ^ prev[idx], written to key word idx.
  - seed = temp at idx 0.
  - seed = registered sub_word_i at idx 4 for Nk 8.
  - seed = previous acc otherwise.
- Then idx increments.
- Nk 8 and idx == 3: after the write, go to SUB_WAIT.
- idx == Nk-1: after the write, go to HOLD.

SUB_WAIT:
- sub_req_o = 1; sub_word_o = key word 3 (held stable).
- On sub_valid_i: capture sub_word_i, set idx = 4, return to RUN.
- sub_valid_i is ignored in every other state.

HOLD:
- key_valid_o = 1; key_o = key register, stable.
- Unused words (index >= Nk) are 0.
- On key_ready_i: go to IDLE; the next start can be accepted the following cycle.

General rules:
- key_o is 0 whenever key_valid_o = 0.
- Latency from accept to key_valid_o: Nk cycles for Nk 4/6; 8 + (SUB_WAIT cycles) for Nk 8.
- start_i outside IDLE is ignored; there is no queueing.
- Changing prev_key_i or temp_word_i after accept has no effect.
- Reset asserted mid-operation returns to the reset state immediately (asynchronous).

Optional Feature:
- Macro KEYXOR_ZEROIZE_EN.
- When defined:
  - Adds input abort_i (1 bit).
  - abort_i in RUN, SUB_WAIT or HOLD: next cycle goes to IDLE, clears the key, temp, sub and acc registers, and pulses err_o.
  - On leaving HOLD, the key register is also cleared to 0.
- When undefined:
  - No abort_i port.
  - Registers keep their last contents after HOLD; key_o is still gated to 0.

Test Plan:
1. AES-128 (FIPS-197 round 1): mode 00, prev = 2b7e1516 28aed2a6 abf71588 09cf4f3c, temp = 8b84eb01 -> after 4 cycles key_valid_o = 1, key_o = a0fafe17 88542cb1 23a33939 2a6c7605, words 4-7 = 0.
2. AES-256 S-box handshake: mode 10, prev = 0, temp = 11111111.
   - Expect sub_req_o with sub_word_o = 11111111.
   - Return sub_word_i = 22222222 three cycles later.
   - Expect words 0-3 = 11111111, words 4-7 = 22222222, key_valid_o at cycle 11.
3. AES-192: mode 01, prev words = 00000001..00000006, temp = 0 -> key_o = 00000001 00000003 00000000 00000004 00000001 00000007, then 0, 0; valid after 6 cycles.
4. Back-pressure: hold key_ready_i = 0 for 5 cycles -> key_o stable and ready_o = 0 throughout; start_i pulses in that window are ignored; after acceptance, ready_o = 1 on the next cycle.
5. Illegal mode and reset: mode 11 with start_i -> err_o pulses once, busy_o stays 0. Assert rst_n low during SUB_WAIT -> all outputs return to reset values, and a fresh mode 00 request runs correctly.
6. With KEYXOR_ZEROIZE_EN defined: abort_i in RUN at idx 2 -> IDLE the next cycle with err_o pulsed. A subsequent mode 00 run with prev = 0 and temp = 0 gives an all-zero key (no residue).
